video_pattern_src: RTL and testbench

- AXI4-Stream video source feeding the HDMI display controller's s_axis_video_* slave port.
- Generates 1366x768 test frames: colour bars, checkerboard, horizontal grey ramp or solid colour, one pixel per accepted beat.
- Marks start-of-frame on tuser and end-of-line on tlast.
- Honours tready backpressure, so it can also feed a FIFO or VDMA in place of the controller.

---
 rtl/video_pattern_pkg.sv | 40 ++++
 rtl/video_pattern_pixel.sv | 42 ++++
 rtl/video_pattern_src.sv | 223 ++++++++++++++++++++++
 tb/tb_video_pattern_src.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_pkg.sv
// Shared pattern codes, colour constants and FSM state type for the video pattern source.
// Colours are packed {B,G,R}, matching the AXI4-Stream video data layout.
package video_pattern_pkg;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_CHECK = 2'd1;
    localparam logic [1:0] PAT_RAMP  = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'h00FFFF;
    localparam logic [23:0] COL_CYAN    = 24'hFFFF00;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'h0000FF;
    localparam logic [23:0] COL_BLUE    = 24'hFF0000;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_e;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] col;
        case (idx)
            3'd0:    col = COL_WHITE;
            3'd1:    col = COL_YELLOW;
            3'd2:    col = COL_CYAN;
            3'd3:    col = COL_GREEN;
            3'd4:    col = COL_MAGENTA;
            3'd5:    col = COL_RED;
            3'd6:    col = COL_BLUE;
            default: col = COL_BLACK;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pixel colour for one (x,y) of the selected test pattern.
// With VIDEO_PATTERN_SRC_MOVING_BAR_EN defined, an 8-pixel white bar at i_bar_pos overlays all patterns.
module video_pattern_pixel
    import video_pattern_pkg::*;
#(
    parameter int unsigned CHECK_SHIFT = 5
) (
    input  logic [1:0]  i_pattern,
    input  logic [2:0]  i_bar_idx,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic [23:0] i_solid,
`ifdef VIDEO_PATTERN_SRC_MOVING_BAR_EN
    input  logic [11:0] i_bar_pos,
`endif
    output logic [23:0] o_data
);

    logic [23:0] w_color;
    logic        w_unused;

    // Only selected coordinate bits feed the colour math.
    assign w_unused = ^{i_x, i_y};

    always_comb begin
        w_color = COL_BLACK;
        case (i_pattern)
            PAT_BARS:  w_color = bar_color(i_bar_idx);
            PAT_CHECK: w_color = (i_x[CHECK_SHIFT] ^ i_y[CHECK_SHIFT]) ? COL_WHITE : COL_BLACK;
            PAT_RAMP:  w_color = {3{i_x[10:3]}};
            default:   w_color = i_solid;
        endcase
`ifdef VIDEO_PATTERN_SRC_MOVING_BAR_EN
        if (i_x >= i_bar_pos && i_x <= i_bar_pos + 12'd7) begin
            w_color = COL_WHITE;
        end
`endif
    end

    assign o_data = w_color;

endmodule

// File: rtl/video_pattern_src.sv
// AXI4-Stream test-frame source: colour bars, checker, grey ramp or solid colour, with backpressure.
// Optional moving white bar overlay enabled by defining VIDEO_PATTERN_SRC_MOVING_BAR_EN.
module video_pattern_src
    import video_pattern_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 1366,
    parameter int unsigned V_ACTIVE    = 768,
    parameter int unsigned BAR_WIDTH   = 171,
    parameter int unsigned CHECK_SHIFT = 5,
    parameter int unsigned FRAME_GAP   = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic [1:0]  i_pattern_sel,
    input  logic [23:0] i_solid_color,
    output logic [23:0] o_m_axis_video_data,
    output logic        o_m_axis_video_valid,
    input  logic        i_m_axis_video_ready,
    output logic        o_m_axis_video_last,
    output logic        o_m_axis_video_user,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [7:0]  o_frame_cnt
);

    localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [11:0] BAR_LAST = 12'(BAR_WIDTH - 1);
    localparam int unsigned GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    state_e            r_state, w_state_d;
    logic [11:0]       r_x, w_x_d;
    logic [11:0]       r_y, w_y_d;
    logic [2:0]        r_bar_idx, w_bar_idx_d;
    logic [11:0]       r_bar_px, w_bar_px_d;
    logic [1:0]        r_pattern, w_pattern_d;
    logic [23:0]       r_solid, w_solid_d;
    logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_d;
    logic              r_valid, w_valid_d;
    logic [23:0]       r_data, w_data_d;
    logic              r_last, w_last_d;
    logic              r_user, w_user_d;
    logic              r_busy, w_busy_d;
    logic              r_frame_done, w_frame_done_d;
    logic [7:0]        r_frame_cnt, w_frame_cnt_d;
`ifdef VIDEO_PATTERN_SRC_MOVING_BAR_EN
    localparam logic [11:0] BAR_POS_MAX = 12'(H_ACTIVE - 8);
    logic [11:0]       r_bar_pos, w_bar_pos_d;
`endif

    logic        w_fire;
    logic        w_eol;
    logic        w_eof;
    logic        w_start;
    logic        w_advance;
    logic        w_load;
    logic [23:0] w_pixel;

    assign w_fire = r_valid & i_m_axis_video_ready;
    assign w_eol  = (r_x == X_LAST);
    assign w_eof  = w_eol & (r_y == Y_LAST);
    assign w_load = w_start | w_advance;

    always_comb begin
        w_state_d      = r_state;
        w_x_d          = r_x;
        w_y_d          = r_y;
        w_bar_idx_d    = r_bar_idx;
        w_bar_px_d     = r_bar_px;
        w_pattern_d    = r_pattern;
        w_solid_d      = r_solid;
        w_gap_cnt_d    = r_gap_cnt;
        w_valid_d      = r_valid;
        w_busy_d       = r_busy;
        w_frame_done_d = 1'b0;
        w_frame_cnt_d  = r_frame_cnt;
        w_start        = 1'b0;
        w_advance      = 1'b0;
`ifdef VIDEO_PATTERN_SRC_MOVING_BAR_EN
        w_bar_pos_d    = r_bar_pos;
`endif
        case (r_state)
            IDLE: begin
                if (i_enable) w_start = 1'b1;
            end
            ACTIVE: begin
                if (w_fire && w_eof) begin
                    w_frame_done_d = 1'b1;
                    w_frame_cnt_d  = r_frame_cnt + 8'd1;
`ifdef VIDEO_PATTERN_SRC_MOVING_BAR_EN
                    w_bar_pos_d = (r_bar_pos + 12'd4 > BAR_POS_MAX) ? 12'd0 : r_bar_pos + 12'd4;
`endif
                    if (FRAME_GAP == 0 && i_enable) begin
                        w_start = 1'b1;
                    end else begin
                        w_valid_d   = 1'b0;
                        w_busy_d    = 1'b0;
                        w_x_d       = 12'd0;
                        w_y_d       = 12'd0;
                        w_gap_cnt_d = GAP_INIT;
                        w_state_d   = (FRAME_GAP == 0) ? IDLE : GAP;
                    end
                end else if (w_fire) begin
                    w_advance = 1'b1;
                    if (w_eol) begin
                        w_x_d       = 12'd0;
                        w_y_d       = r_y + 12'd1;
                        w_bar_idx_d = 3'd0;
                        w_bar_px_d  = 12'd0;
                    end else begin
                        w_x_d = r_x + 12'd1;
                        // Bar index tracks x without a divider; it sticks at the last bar.
                        if (r_bar_px == BAR_LAST) begin
                            w_bar_px_d = 12'd0;
                            if (r_bar_idx != 3'd7) w_bar_idx_d = r_bar_idx + 3'd1;
                        end else begin
                            w_bar_px_d = r_bar_px + 12'd1;
                        end
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) w_state_d = IDLE;
                else                 w_gap_cnt_d = r_gap_cnt - 1'b1;
            end
            default: w_state_d = IDLE;
        endcase

        if (w_start) begin
            w_state_d   = ACTIVE;
            w_pattern_d = i_pattern_sel;
            w_solid_d   = i_solid_color;
            w_x_d       = 12'd0;
            w_y_d       = 12'd0;
            w_bar_idx_d = 3'd0;
            w_bar_px_d  = 12'd0;
            w_valid_d   = 1'b1;
            w_busy_d    = 1'b1;
        end
    end

    // Beat payload is computed from the next coordinates so it is registered alongside them.
    always_comb begin
        w_data_d = r_data;
        w_last_d = r_last;
        w_user_d = r_user;
        if (w_load) begin
            w_data_d = w_pixel;
            w_last_d = (w_x_d == X_LAST);
            w_user_d = w_start;
        end else if (!w_valid_d) begin
            w_last_d = 1'b0;
            w_user_d = 1'b0;
        end
    end

    video_pattern_pixel #(
        .CHECK_SHIFT(CHECK_SHIFT)
    ) u_pixel (
        .i_pattern (w_pattern_d),
        .i_bar_idx (w_bar_idx_d),
        .i_x       (w_x_d),
        .i_y       (w_y_d),
        .i_solid   (w_solid_d),
`ifdef VIDEO_PATTERN_SRC_MOVING_BAR_EN
        .i_bar_pos (w_bar_pos_d),
`endif
        .o_data    (w_pixel)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_bar_idx    <= '0;
            r_bar_px     <= '0;
            r_pattern    <= '0;
            r_solid      <= '0;
            r_gap_cnt    <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_last       <= 1'b0;
            r_user       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
`ifdef VIDEO_PATTERN_SRC_MOVING_BAR_EN
            r_bar_pos    <= '0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_x          <= w_x_d;
            r_y          <= w_y_d;
            r_bar_idx    <= w_bar_idx_d;
            r_bar_px     <= w_bar_px_d;
            r_pattern    <= w_pattern_d;
            r_solid      <= w_solid_d;
            r_gap_cnt    <= w_gap_cnt_d;
            r_valid      <= w_valid_d;
            r_data       <= w_data_d;
            r_last       <= w_last_d;
            r_user       <= w_user_d;
            r_busy       <= w_busy_d;
            r_frame_done <= w_frame_done_d;
            r_frame_cnt  <= w_frame_cnt_d;
`ifdef VIDEO_PATTERN_SRC_MOVING_BAR_EN
            r_bar_pos    <= w_bar_pos_d;
`endif
        end
    end

    assign o_m_axis_video_data  = r_data;
    assign o_m_axis_video_valid = r_valid;
    assign o_m_axis_video_last  = r_last;
    assign o_m_axis_video_user  = r_user;
    assign o_busy               = r_busy;
    assign o_frame_done         = r_frame_done;
    assign o_frame_cnt          = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_src.sv
// Scoreboard bench for video_pattern_src on a 16x4 frame; a second instance with FRAME_GAP=3
// exercises inter-frame gaps and frame counter wrap.
module tb_video_pattern_src;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int BW = 2;
    localparam int CS = 1;
    localparam int GP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        en_gap = 1'b0;
    logic        ready = 1'b1;
    logic        rand_ready = 1'b0;
    logic [1:0]  pat_sel = 2'd0;
    logic [23:0] solid = 24'd0;

    logic [23:0] data, g_data;
    logic        valid, last, user, busy, fd;
    logic        g_valid, g_last, g_user, g_busy, g_fd;
    logic [7:0]  cnt, g_cnt;

    always #5 clk = ~clk;

    video_pattern_src #(
        .H_ACTIVE(H), .V_ACTIVE(V), .BAR_WIDTH(BW), .CHECK_SHIFT(CS), .FRAME_GAP(0)
    ) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_pattern_sel(pat_sel),
        .i_solid_color(solid), .o_m_axis_video_data(data), .o_m_axis_video_valid(valid),
        .i_m_axis_video_ready(ready), .o_m_axis_video_last(last), .o_m_axis_video_user(user),
        .o_busy(busy), .o_frame_done(fd), .o_frame_cnt(cnt)
    );

    video_pattern_src #(
        .H_ACTIVE(H), .V_ACTIVE(V), .BAR_WIDTH(BW), .CHECK_SHIFT(CS), .FRAME_GAP(GP)
    ) u_dut_gap (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en_gap), .i_pattern_sel(pat_sel),
        .i_solid_color(solid), .o_m_axis_video_data(g_data), .o_m_axis_video_valid(g_valid),
        .i_m_axis_video_ready(1'b1), .o_m_axis_video_last(g_last), .o_m_axis_video_user(g_user),
        .o_busy(g_busy), .o_frame_done(g_fd), .o_frame_cnt(g_cnt)
    );

    typedef struct packed {
        logic [23:0] data;
        logic        last;
        logic        user;
        logic        eof;
        logic        nobubble;
    } beat_t;

    beat_t    exp_q[$];
    int       checks = 0;
    int       errors = 0;
    int       mon_beats = 0;
    int       mon_frames = 0;
    int       frames_pushed = 0;
    int       gap_pulses = 0;
    logic [7:0] model_cnt = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'h00FFFF;
            2: return 24'hFFFF00;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'h0000FF;
            6: return 24'hFF0000;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic int bar_pos_of(input int k);
        int bp = 0;
        for (int i = 0; i < k; i++) bp = (bp + 4 > H - 8) ? 0 : bp + 4;
        return bp;
    endfunction

    function automatic logic [23:0] ref_pixel(input int pat, input logic [23:0] sol,
                                              input int x, input int y, input int k);
        logic [23:0] c;
        logic [7:0]  v;
        int          idx;
        case (pat)
            0: begin
                idx = x / BW;
                if (idx > 7) idx = 7;
                c = bar_colour(idx);
            end
            1: c = ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2: begin
                v = 8'((x >> 3) & 255);
                c = {v, v, v};
            end
            default: c = sol;
        endcase
`ifdef VIDEO_PATTERN_SRC_MOVING_BAR_EN
        if (x >= bar_pos_of(k) && x <= bar_pos_of(k) + 7) c = 24'hFFFFFF;
`else
        if (k < 0) c = 24'h0;
`endif
        return c;
    endfunction

    task automatic push_frame(input int pat, input logic [23:0] sol, input bit chained);
        beat_t b;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                b.data     = ref_pixel(pat, sol, x, y, frames_pushed);
                b.last     = (x == H - 1);
                b.user     = (x == 0 && y == 0);
                b.eof      = (x == H - 1 && y == V - 1);
                b.nobubble = b.eof && chained;
                exp_q.push_back(b);
            end
        end
        frames_pushed++;
    endtask

    task automatic pulse(input logic [1:0] pat, input logic [23:0] sol);
        @(posedge clk);
        #1;
        pat_sel = pat;
        solid   = sol;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (mon_beats < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (mon_beats < target) check("beat_wait_timeout", 64'(mon_beats), 64'(target));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Scoreboard monitor for the gapless instance.
    initial begin
        logic        prev_stall = 1'b0;
        logic        prev_eof = 1'b0;
        logic        prev_nobub = 1'b0;
        logic [25:0] prev_beat = '0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_eof   = 1'b0;
                prev_nobub = 1'b0;
                model_cnt  = 8'd0;
            end else begin
                if (prev_stall) check("stall_hold", {valid, data, last, user}, {1'b1, prev_beat});
                if (prev_eof || fd) check("frame_done", 64'(fd), 64'(prev_eof));
                if (prev_eof) check("frame_cnt", 64'(cnt), 64'(model_cnt));
                if (prev_nobub) check("no_bubble", {valid, user}, 2'b11);
                if (prev_eof && !prev_nobub) check("idle_after_frame", {valid, busy}, 2'b00);
                if (valid) check("busy_with_valid", 64'(busy), 64'd1);
                prev_eof   = 1'b0;
                prev_nobub = 1'b0;
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {data, last, user}, 64'd0 - 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {data, last, user}, {e.data, e.last, e.user});
                        mon_beats++;
                        if (e.eof) begin
                            model_cnt++;
                            mon_frames++;
                            prev_eof   = 1'b1;
                            prev_nobub = e.nobubble;
                        end
                    end
                end
                prev_stall = valid && !ready;
                prev_beat  = {data, last, user};
            end
        end
    end

    // Gap instance: idle cycles between frames and the completed-frame counter.
    initial begin
        bit counting = 1'b0;
        int low = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap_pulses = 0;
                counting   = 1'b0;
            end else if (g_fd) begin
                gap_pulses++;
                check("gap_frame_cnt", 64'(g_cnt), 64'(gap_pulses % 256));
                check("gap_done_idle", {g_valid, g_busy}, 2'b00);
                counting = 1'b1;
                low      = 0;
            end else if (counting) begin
                if (!g_valid) begin
                    low++;
                end else begin
                    check("gap_length", 64'(low), 64'(GP));
                    counting = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int f0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {data, valid, last, user, busy, fd, cnt}, 64'd0);
        check("reset_outputs_gap", {g_data, g_valid, g_last, g_user, g_busy, g_fd, g_cnt}, 64'd0);
        rst_n = 1'b1;

        // Bars, ready held high, single enable pulse.
        push_frame(0, 24'h0, 1'b0);
        pulse(2'd0, 24'h0);
        wait_drain("bars_ready");

        // Same frame under random backpressure.
        rand_ready = 1'b1;
        push_frame(0, 24'h0, 1'b0);
        pulse(2'd0, 24'h0);
        wait_drain("bars_stall");

        // Each non-bar pattern, then a couple of random ones.
        for (int i = 0; i < 5; i++) begin
            logic [1:0]  p;
            logic [23:0] s;
            p = (i < 3) ? 2'(i + 1) : 2'($urandom_range(0, 3));
            s = 24'($urandom);
            push_frame(int'(p), s, 1'b0);
            pulse(p, s);
            wait_drain("pattern_mix");
        end

        // Continuous frames: mid-frame pattern change only affects the following frame.
        push_frame(0, 24'h0, 1'b1);
        push_frame(3, 24'h123456, 1'b0);
        base = mon_beats;
        f0   = mon_frames;
        @(posedge clk);
        #1;
        pat_sel = 2'd0;
        solid   = 24'h0;
        enable  = 1'b1;
        wait_beats(base + 20);
        @(posedge clk);
        #1;
        pat_sel = 2'd3;
        solid   = 24'h123456;
        wait_beats(base + H * V);
        if (mon_frames > f0) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        wait_drain("chained");

        // Asynchronous reset while pixel (5,2) is presented.
        rand_ready = 1'b0;
        push_frame(2, 24'h0, 1'b0);
        base = mon_beats;
        pulse(2'd2, 24'h0);
        wait_beats(base + 2 * H + 5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midframe_reset", {data, valid, last, user, busy, fd, cnt}, 64'd0);
        exp_q.delete();
        frames_pushed = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_frame(1, 24'h0, 1'b0);
        pulse(2'd1, 24'h0);
        wait_drain("after_reset");

        // 256 frames with gaps; counter must wrap back to zero.
        en_gap = 1'b1;
        for (int n = 0; n < 30000 && gap_pulses < 256; n++) @(negedge clk);
        #1;
        en_gap = 1'b0;
        check("gap_frames", 64'(gap_pulses), 64'd256);
        check("frame_cnt_wrap", 64'(g_cnt), 64'd0);
        repeat (10) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
